// File: rtl/ddr_burst_wr_engine_if.sv
// AXI4 write-side bundle (AW, W, B) between the burst engine and one DDR interconnect port.
// Latency: none, wires only.
// Backpressure: valid/ready on every channel; the master holds its payload while valid is high.
interface ddr_burst_wr_engine_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]            m_awlen;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  m_wready;
    logic                  m_bvalid;
    logic [1:0]            m_bresp;
    logic                  m_bready;

    modport master (
        output m_awaddr, m_awlen, m_awvalid,
        input  m_awready,
        output m_wdata, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bvalid, m_bresp,
        output m_bready
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awvalid,
        output m_awready,
        input  m_wdata, m_wlast, m_wvalid,
        output m_wready,
        output m_bvalid, m_bresp,
        input  m_bready
    );
endinterface

// File: rtl/ddr_burst_wr_engine.sv
// DDR write burst engine: one request edge -> req_num aligned AXI4 bursts from the pixel FIFO, then req_done.
// Latency: req_done 2 cycles after an accepted zero-length edge; one burst outstanding at a time.
// Backpressure: AW/W/B valid-ready honoured, FIFO popped only on W handshake; DDR_WR_ERR_CNT_EN adds wr_err/wr_err_cnt.
module ddr_burst_wr_engine #(
    parameter int ADDR_WIDTH     = 30,
    parameter int WR_NUM_WIDTH   = 16,
    parameter int DATA_WIDTH     = 256,
    parameter int BURST_LEN      = 8,
    parameter int FIFO_CNT_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_calib_complete,
    input  logic                      req_valid,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [WR_NUM_WIDTH-1:0]   req_num,
    output logic                      req_done,
    output logic                      busy,
    input  logic [FIFO_CNT_WIDTH-1:0] fifo_rd_cnt,
    input  logic [DATA_WIDTH-1:0]     fifo_rdata,
    output logic                      fifo_rd_en,
    ddr_burst_wr_engine_if.master     axi
`ifdef DDR_WR_ERR_CNT_EN
    ,
    output logic                      wr_err,
    output logic [15:0]               wr_err_cnt
`endif
);
    localparam int BURST_BYTES = DATA_WIDTH / 8 * BURST_LEN;
    localparam int ALIGN_BITS  = $clog2(BURST_BYTES);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [ADDR_WIDTH-1:0]     ALIGN_MASK  = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_STEP   = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [BEAT_W-1:0]         LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [FIFO_CNT_WIDTH-1:0] BURST_WORDS = FIFO_CNT_WIDTH'(BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                  state;
    logic                    req_valid_q;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [WR_NUM_WIDTH-1:0] num_r;
    logic [WR_NUM_WIDTH-1:0] burst_cnt;
    logic [WR_NUM_WIDTH-1:0] burst_nxt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [BEAT_W-1:0]       beat_nxt;
    logic                    accept;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;

    // Edges seen outside IDLE are dropped, never queued.
    assign accept    = (state == S_IDLE) && init_calib_complete && req_valid && !req_valid_q;
    assign aw_hs     = axi.m_awvalid && axi.m_awready;
    assign w_hs      = axi.m_wvalid && axi.m_wready;
    assign b_hs      = axi.m_bvalid && axi.m_bready;
    assign burst_nxt = burst_cnt + 1'b1;
    assign beat_nxt  = beat_cnt + 1'b1;

    assign fifo_rd_en   = w_hs;
    assign axi.m_awaddr = addr_r;
    assign axi.m_awlen  = 8'(BURST_LEN - 1);
    assign axi.m_wdata  = fifo_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            req_valid_q   <= 1'b0;
            addr_r        <= '0;
            num_r         <= '0;
            burst_cnt     <= '0;
            beat_cnt      <= '0;
            busy          <= 1'b0;
            req_done      <= 1'b0;
            axi.m_awvalid <= 1'b0;
            axi.m_wvalid  <= 1'b0;
            axi.m_wlast   <= 1'b0;
            axi.m_bready  <= 1'b0;
        end else begin
            req_valid_q <= req_valid;
            req_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_r    <= req_addr & ~ALIGN_MASK;
                        num_r     <= req_num;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A whole burst must be buffered so wvalid never gaps mid-burst.
                    if (num_r == '0) begin
                        req_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (fifo_rd_cnt >= BURST_WORDS) begin
                        axi.m_awvalid <= 1'b1;
                        state         <= S_AW;
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        axi.m_awvalid <= 1'b0;
                        axi.m_wvalid  <= 1'b1;
                        axi.m_wlast   <= (LAST_BEAT == '0);
                        beat_cnt      <= '0;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        beat_cnt    <= beat_nxt;
                        axi.m_wlast <= (beat_nxt == LAST_BEAT);
                        if (axi.m_wlast) begin
                            axi.m_wvalid <= 1'b0;
                            axi.m_wlast  <= 1'b0;
                            axi.m_bready <= 1'b1;
                            state        <= S_B;
                        end
                    end
                end
                S_B: begin
                    // Response code does not affect sequencing; the address wraps silently.
                    if (b_hs) begin
                        axi.m_bready <= 1'b0;
                        addr_r       <= addr_r + ADDR_STEP;
                        burst_cnt    <= burst_nxt;
                        if (burst_nxt == num_r) begin
                            req_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DDR_WR_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err     <= 1'b0;
            wr_err_cnt <= '0;
        end else if (b_hs && (axi.m_bresp != 2'b00)) begin
            wr_err <= 1'b1;
            if (wr_err_cnt != 16'hFFFF) begin
                wr_err_cnt <= wr_err_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_bresp;
    assign unused_bresp = ^axi.m_bresp;
`endif
endmodule

// File: tb/tb_ddr_burst_wr_engine.sv
// Directed bench for ddr_burst_wr_engine: vector table of transactions plus hand-written corner sequences.
module tb_ddr_burst_wr_engine;
    localparam int AW = 30;
    localparam int NW = 16;
    localparam int DW = 256;
    localparam int BL = 8;
    localparam int CW = 10;

    logic          clk;
    logic          rst_n;
    logic          init_calib_complete;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [NW-1:0] req_num;
    logic          req_done;
    logic          busy;
    logic [CW-1:0] fifo_rd_cnt;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd_en;
`ifdef DDR_WR_ERR_CNT_EN
    logic          wr_err;
    logic [15:0]   wr_err_cnt;
`endif

    ddr_burst_wr_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_bus ();

    ddr_burst_wr_engine #(
        .ADDR_WIDTH(AW), .WR_NUM_WIDTH(NW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FIFO_CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init_calib_complete(init_calib_complete),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_num(req_num),
        .req_done(req_done),
        .busy(busy),
        .fifo_rd_cnt(fifo_rd_cnt),
        .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en),
        .axi(axi_bus)
`ifdef DDR_WR_ERR_CNT_EN
        ,
        .wr_err(wr_err),
        .wr_err_cnt(wr_err_cnt)
`endif
    );

    assign axi_bus.m_bresp = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int head = 0;
    int fifo_avail = 0;
    int pops = 0;
    int aw_cnt = 0;
    int w_bursts = 0;
    int done_cnt = 0;
    int tb_beat = 0;
    int aw_delay = 0;
    int b_delay = 0;
    int aw_wait = 0;
    int b_wait = 0;
    bit w_toggle = 1'b0;
    bit w_phase = 1'b0;
    bit pop_pend = 1'b0;
    bit aw_hold_vld = 1'b0;
    logic [AW-1:0] exp_base = '0;
    logic [AW-1:0] aw_hold = '0;
    logic [AW-1:0] exp_addr;

    typedef struct {
        logic [AW-1:0] addr;
        int            num;
        int            aw_dly;
        bit            w_tgl;
        int            b_dly;
        logic [AW-1:0] exp_aw0;
        int            exp_aw;
        int            exp_pops;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [DW-1:0] word(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(i);
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model and AXI slave responder; decisions at the falling edge, checks 1 time unit later.
    always @(negedge clk) begin
        if (!rst_n) begin
            head = 0;
            pop_pend = 1'b0;
            tb_beat = 0;
            aw_wait = 0;
            b_wait = 0;
            w_phase = 1'b0;
            aw_hold_vld = 1'b0;
            axi_bus.m_awready = 1'b0;
            axi_bus.m_wready = 1'b0;
            axi_bus.m_bvalid = 1'b0;
            fifo_rd_cnt = '0;
            fifo_rdata = word(0);
        end else begin
            if (pop_pend) head++;
            pop_pend = 1'b0;
            fifo_rdata = word(head);
            fifo_rd_cnt = CW'((fifo_avail > head) ? (fifo_avail - head) : 0);
            if (axi_bus.m_awvalid) begin
                axi_bus.m_awready = (aw_wait >= aw_delay);
                if (aw_wait < aw_delay) aw_wait++;
            end else begin
                axi_bus.m_awready = (aw_delay == 0);
                aw_wait = 0;
            end
            w_phase = ~w_phase;
            axi_bus.m_wready = w_toggle ? w_phase : 1'b1;
            if (axi_bus.m_bready) begin
                axi_bus.m_bvalid = (b_wait >= b_delay);
                if (b_wait < b_delay) b_wait++;
            end else begin
                axi_bus.m_bvalid = 1'b0;
                b_wait = 0;
            end
            #1;
            if (axi_bus.m_awvalid) begin
                chk("aw_no_overlap", 64'({axi_bus.m_wvalid, axi_bus.m_bready}), 64'd0);
                if (aw_hold_vld) chk("aw_addr_stable", 64'(axi_bus.m_awaddr), 64'(aw_hold));
            end
            aw_hold_vld = axi_bus.m_awvalid && !axi_bus.m_awready;
            aw_hold = axi_bus.m_awaddr;
            if (axi_bus.m_awvalid && axi_bus.m_awready) begin
                exp_addr = exp_base + AW'(aw_cnt * 256);
                chk("awaddr", 64'(axi_bus.m_awaddr), 64'(exp_addr));
                chk("awlen", 64'(axi_bus.m_awlen), 64'd7);
                aw_cnt++;
            end
            if (tb_beat != 0) chk("wvalid_gap", 64'(axi_bus.m_wvalid), 64'd1);
            if (axi_bus.m_wvalid) chk("w_after_aw", 64'(aw_cnt > w_bursts), 64'd1);
            if (axi_bus.m_wvalid && axi_bus.m_wready) begin
                chk_w("wdata", axi_bus.m_wdata, word(head));
                chk("wlast", 64'(axi_bus.m_wlast), 64'(tb_beat == BL - 1));
                chk("rd_en", 64'(fifo_rd_en), 64'd1);
                pop_pend = 1'b1;
                pops++;
                tb_beat++;
                if (tb_beat == BL) begin
                    tb_beat = 0;
                    w_bursts++;
                end
            end
            if (req_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        aw_cnt = 0;
        w_bursts = 0;
        pops = 0;
        done_cnt = 0;
    endtask

    task automatic start_req(input logic [AW-1:0] a, input int n);
        req_addr = a;
        req_num = NW'(n);
        req_valid = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (done_cnt == 0 && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_req_done"}, 64'(req_done), 64'd0);
        chk({tag, "_awvalid"}, 64'(axi_bus.m_awvalid), 64'd0);
        chk({tag, "_wvalid"}, 64'(axi_bus.m_wvalid), 64'd0);
        chk({tag, "_wlast"}, 64'(axi_bus.m_wlast), 64'd0);
        chk({tag, "_bready"}, 64'(axi_bus.m_bready), 64'd0);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_awaddr"}, 64'(axi_bus.m_awaddr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        vecs[0] = '{30'h0008_0000, 3, 0, 1'b0, 0,  30'h0008_0000, 3, 24};
        vecs[1] = '{30'h0000_1234, 2, 5, 1'b1, 10, 30'h0000_1200, 2, 16};
        vecs[2] = '{30'h3FFF_FF80, 2, 0, 1'b1, 0,  30'h3FFF_FF00, 2, 16};
        vecs[3] = '{30'h0000_0000, 1, 2, 1'b0, 3,  30'h0000_0000, 1, 8};

        rst_n = 1'b0;
        init_calib_complete = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_num = '0;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        for (int v = 0; v < 4; v++) begin
            clear_counts();
            aw_delay = vecs[v].aw_dly;
            w_toggle = vecs[v].w_tgl;
            b_delay = vecs[v].b_dly;
            exp_base = vecs[v].exp_aw0;
            fifo_avail = head + vecs[v].exp_pops;
            tick(1);
            start_req(vecs[v].addr, vecs[v].num);
            wait_done("vec_done_seen", 3000);
            req_valid = 1'b0;
            tick(4);
            chk("vec_aw_count", 64'(aw_cnt), 64'(vecs[v].exp_aw));
            chk("vec_pops", 64'(pops), 64'(vecs[v].exp_pops));
            chk("vec_done_once", 64'(done_cnt), 64'd1);
            chk("vec_busy_after", 64'(busy), 64'd0);
        end
        aw_delay = 0;
        w_toggle = 1'b0;
        b_delay = 0;

        // Zero-length request: done two cycles after the edge, no AXI traffic.
        clear_counts();
        tick(1);
        start_req(30'h40, 0);
        tick(1);
        chk("zero_busy_accept", 64'(busy), 64'd1);
        chk("zero_done_early", 64'(req_done), 64'd0);
        tick(1);
        chk("zero_done_pulse", 64'(req_done), 64'd1);
        chk("zero_busy_done", 64'(busy), 64'd1);
        tick(1);
        chk("zero_done_clear", 64'(req_done), 64'd0);
        chk("zero_busy_clear", 64'(busy), 64'd0);
        req_valid = 1'b0;
        tick(3);
        chk("zero_no_aw", 64'(aw_cnt), 64'd0);
        chk("zero_done_once", 64'(done_cnt), 64'd1);

        // FIFO starvation: 7 words is one short of a burst.
        clear_counts();
        exp_base = 30'h2000;
        fifo_avail = head + 7;
        tick(1);
        start_req(30'h2000, 1);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("starve_awvalid", 64'(axi_bus.m_awvalid), 64'd0);
        end
        chk("starve_busy", 64'(busy), 64'd1);
        fifo_avail = head + 8;
        wait_done("starve_done_seen", 500);
        req_valid = 1'b0;
        tick(3);
        chk("starve_aw_count", 64'(aw_cnt), 64'd1);
        chk("starve_pops", 64'(pops), 64'd8);
        chk("starve_done_once", 64'(done_cnt), 64'd1);

        // Calibration gating, then a second edge and a calibration drop mid-transaction.
        clear_counts();
        init_calib_complete = 1'b0;
        exp_base = 30'h3000;
        fifo_avail = head + 16;
        b_delay = 10;
        tick(1);
        start_req(30'h3000, 2);
        tick(5);
        chk("calib_gate_busy", 64'(busy), 64'd0);
        chk("calib_gate_aw", 64'(aw_cnt), 64'd0);
        req_valid = 1'b0;
        init_calib_complete = 1'b1;
        tick(2);
        start_req(30'h3000, 2);
        c = 0;
        while (aw_cnt == 0 && c < 200) begin
            tick(1);
            c++;
        end
        chk("second_edge_first_aw", 64'(aw_cnt), 64'd1);
        req_valid = 1'b0;
        tick(1);
        init_calib_complete = 1'b0;
        start_req(30'h5000, 5);
        wait_done("second_edge_done_seen", 1000);
        tick(20);
        chk("second_edge_done_once", 64'(done_cnt), 64'd1);
        chk("second_edge_aw_count", 64'(aw_cnt), 64'd2);
        chk("second_edge_pops", 64'(pops), 64'd16);
        chk("second_edge_busy", 64'(busy), 64'd0);
        req_valid = 1'b0;
        init_calib_complete = 1'b1;
        b_delay = 0;
        tick(2);

        // Asynchronous reset in the middle of a burst.
        clear_counts();
        exp_base = 30'h4000;
        fifo_avail = head + 16;
        tick(1);
        start_req(30'h4000, 2);
        c = 0;
        while (tb_beat != 4 && c < 200) begin
            tick(1);
            c++;
        end
        chk("rst_reach_beat4", 64'(tb_beat), 64'd4);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        req_valid = 1'b0;
        tick(3);
        rst_n = 1'b1;
        clear_counts();
        fifo_avail = 8;
        exp_base = 30'h100;
        tick(2);
        start_req(30'h1F0, 1);
        wait_done("post_rst_done_seen", 500);
        req_valid = 1'b0;
        tick(3);
        chk("post_rst_aw_count", 64'(aw_cnt), 64'd1);
        chk("post_rst_pops", 64'(pops), 64'd8);
        chk("post_rst_done_once", 64'(done_cnt), 64'd1);

`ifdef DDR_WR_ERR_CNT_EN
        chk("wr_err_clean", 64'(wr_err), 64'd0);
        chk("wr_err_cnt_clean", 64'(wr_err_cnt), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
